// File: rtl/led_breath_pwm_if.sv
// Sequencer-facing signal bundle of led_breath_pwm: target levels in, LED drive and ramp status out.
interface led_breath_pwm_if #(
  parameter int CH = 4
);
  logic [CH-1:0] level_in;
  logic [CH-1:0] led_pwm;
  logic [CH-1:0] ramping;

  modport master (output level_in, input led_pwm, input ramping);
  modport slave  (input level_in, output led_pwm, output ramping);
endinterface

// File: rtl/led_breath_pwm.sv
// Per-channel PWM fade-in/fade-out ("breathing") of sequencer on/off levels.
// Define GAMMA_EN for a quadratic perceptual duty curve; default is linear with no multiplier.
module led_breath_pwm #(
  parameter int CH       = 4,
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 195_312
) (
  input logic            clk,
  input logic            rst_n,
  led_breath_pwm_if.slave bus
);
  localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
  localparam logic [PWM_BITS-1:0] DUTY_PRE  = DUTY_MAX - 1'b1;
  localparam logic [PWM_BITS-1:0] DUTY_ONE  = PWM_BITS'(1);
  localparam int                  PRESC_W   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PRESC_W-1:0]  PRESC_END = PRESC_W'(STEP_DIV - 1);

  typedef enum logic [1:0] {S_OFF, S_RISE, S_ON, S_FALL} ramp_state_e;

  logic [CH-1:0]       level_q;
  logic [PRESC_W-1:0]  presc;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] pwm_cnt_next;
  logic                tick;
  logic                wrap;

  ramp_state_e         state      [CH];
  ramp_state_e         state_next [CH];
  logic [PWM_BITS-1:0] duty       [CH];
  logic [PWM_BITS-1:0] duty_next  [CH];
  logic [PWM_BITS-1:0] cmp        [CH];
  logic [PWM_BITS-1:0] cmp_next   [CH];
  logic [CH-1:0]       led_q;
  logic [CH-1:0]       led_next;
  logic [CH-1:0]       ramping_c;

  function automatic logic [PWM_BITS-1:0] eff_of(input logic [PWM_BITS-1:0] c);
`ifdef GAMMA_EN
    logic [2*PWM_BITS-1:0] sq;
    sq = {{PWM_BITS{1'b0}}, c} * {{PWM_BITS{1'b0}}, c};
    return sq[2*PWM_BITS-1:PWM_BITS];
`else
    return c;
`endif
  endfunction

  assign tick         = (presc == PRESC_END);
  assign wrap         = (pwm_cnt == DUTY_MAX);
  assign pwm_cnt_next = pwm_cnt + 1'b1;

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      presc   <= '0;
      pwm_cnt <= '0;
    end else begin
      level_q <= bus.level_in;
      presc   <= tick ? '0 : presc + 1'b1;
      pwm_cnt <= pwm_cnt_next;
    end
  end

  // Ramp FSMs. A reversal or a ramp leaving a limit consumes the coinciding tick.
  // A ramp that starts already at its end limit (reversed before any step) settles on the next tick.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      // NOTE: defaults first so no path leaves a variable unassigned (no latch).
      state_next[i] = state[i];
      duty_next[i]  = duty[i];
      unique case (state[i])
        S_OFF:  if (level_q[i]) state_next[i] = S_RISE;
        S_RISE: begin
          if (!level_q[i]) begin
            state_next[i] = S_FALL;
          end else if (tick) begin
            if (duty[i] != DUTY_MAX) duty_next[i] = duty[i] + 1'b1;
            if (duty[i] >= DUTY_PRE) state_next[i] = S_ON;
          end
        end
        S_ON:   if (!level_q[i]) state_next[i] = S_FALL;
        S_FALL: begin
          if (level_q[i]) begin
            state_next[i] = S_RISE;
          end else if (tick) begin
            if (duty[i] != '0) duty_next[i] = duty[i] - 1'b1;
            if (duty[i] <= DUTY_ONE) state_next[i] = S_OFF;
          end
        end
        default: state_next[i] = S_OFF;
      endcase
    end
  end

  // The compare value is taken at the period boundary; the LED bit is computed from the value cmp
  // will hold in the coming cycle, so each period shows exactly eff high cycles starting at count 0.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      cmp_next[i]  = wrap ? duty[i] : cmp[i];
      led_next[i]  = (cmp_next[i] == DUTY_MAX) || (pwm_cnt_next < eff_of(cmp_next[i]));
      ramping_c[i] = (state[i] == S_RISE) || (state[i] == S_FALL);
    end
  end

  // NOTE: these arrays are control state (a few flops per channel), so they take the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        state[i] <= S_OFF;
        duty[i]  <= '0;
        cmp[i]   <= '0;
      end
      led_q <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        state[i] <= state_next[i];
        duty[i]  <= duty_next[i];
        cmp[i]   <= cmp_next[i];
      end
      led_q <= led_next;
    end
  end

  assign bus.led_pwm = led_q;
  assign bus.ramping = ramping_c;
endmodule
